if_fetch: RTL and testbench

//   Instruction-fetch stage directly downstream of the PC register. Takes the current PC and

---
 rtl/if_fetch.sv | 170 +++++++++++++++++
 tb/tb_if_fetch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues the PC on an SRAM-like bus, tracks in-order requests and
// buffers {pc, inst} for decode. Optional misaligned-PC trap entry under `IF_ADEL_CHECK_EN.
module if_fetch #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef IF_ADEL_CHECK_EN
  ,
  output logic        if_adel
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W+1:0] DEPTH_W = (CNT_W + 2)'(DEPTH);

  // In-flight request queue (PCs awaiting data) and output buffer.
  logic [31:0]      fl_pc_q [DEPTH];
  logic [PTR_W-1:0] fl_wr_q, fl_wr_d, fl_rd_q, fl_rd_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  logic [31:0]      bf_pc_q   [DEPTH];
  logic [31:0]      bf_inst_q [DEPTH];
  logic [PTR_W-1:0] bf_wr_q, bf_wr_d, bf_rd_q, bf_rd_d;
  logic [CNT_W-1:0] bf_cnt_q, bf_cnt_d;

  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W+1:0] used;
  logic             fetch_block, adel_push;
  logic             accept, drop, resp, bf_push, bf_pop;
  logic [31:0]      push_pc, push_inst;

`ifdef IF_ADEL_CHECK_EN
  logic bf_adel_q [DEPTH];
  logic adel_hold_q, adel_hold_d;
  logic misaligned;

  assign misaligned  = (pc[1:0] != 2'b00);
  // Pending discards are ignored here: the trap entry only needs buffer space.
  assign adel_push   = !reset && !flush && misaligned && !adel_hold_q &&
                       (fl_cnt_q == '0) && (bf_cnt_q < DEPTH_C);
  assign fetch_block = misaligned || adel_hold_q;
  assign adel_hold_d = flush ? 1'b0 : (adel_hold_q || adel_push);
`else
  assign adel_push   = 1'b0;
  assign fetch_block = 1'b0;
`endif

  assign used      = {2'b00, fl_cnt_q} + {2'b00, discard_q} + {2'b00, bf_cnt_q};
  assign inst_req  = !reset && !flush && !fetch_block && (used < DEPTH_W);
  assign inst_addr = pc;
  assign accept    = inst_req && inst_addr_ok;
  assign pc_stall  = reset || (!accept && !flush);

  assign drop    = inst_data_ok && (discard_q != '0);
  assign resp    = inst_data_ok && (discard_q == '0) && (fl_cnt_q != '0);
  assign bf_push = (resp || adel_push) && !flush;
  assign bf_pop  = if_valid && if_ready;

  always_comb begin
    push_pc   = fl_pc_q[fl_rd_q];
    push_inst = inst_rdata;
`ifdef IF_ADEL_CHECK_EN
    if (adel_push) begin
      push_pc   = pc;
      push_inst = '0;
    end
`endif
  end

  always_comb begin
    fl_wr_d   = fl_wr_q;
    fl_rd_d   = fl_rd_q;
    fl_cnt_d  = fl_cnt_q;
    bf_wr_d   = bf_wr_q;
    bf_rd_d   = bf_rd_q;
    bf_cnt_d  = bf_cnt_q;
    discard_d = discard_q;

    if (accept) begin
      fl_wr_d  = fl_wr_q + 1'b1;
      fl_cnt_d = fl_cnt_d + 1'b1;
    end
    if (resp) begin
      fl_rd_d  = fl_rd_q + 1'b1;
      fl_cnt_d = fl_cnt_d - 1'b1;
    end
    if (drop) discard_d = discard_q - 1'b1;

    if (bf_push) begin
      bf_wr_d  = bf_wr_q + 1'b1;
      bf_cnt_d = bf_cnt_d + 1'b1;
    end
    if (bf_pop) begin
      bf_rd_d  = bf_rd_q + 1'b1;
      bf_cnt_d = bf_cnt_d - 1'b1;
    end

    // Every request still owed a response becomes a discard, except one answered right now.
    if (flush) begin
      discard_d = discard_d + (fl_cnt_q - CNT_W'(resp));
      fl_rd_d   = fl_wr_q;
      fl_cnt_d  = '0;
      bf_rd_d   = bf_wr_q;
      bf_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fl_wr_q   <= '0;
      fl_rd_q   <= '0;
      fl_cnt_q  <= '0;
      bf_wr_q   <= '0;
      bf_rd_q   <= '0;
      bf_cnt_q  <= '0;
      discard_q <= '0;
`ifdef IF_ADEL_CHECK_EN
      adel_hold_q <= 1'b0;
`endif
    end else begin
      fl_wr_q   <= fl_wr_d;
      fl_rd_q   <= fl_rd_d;
      fl_cnt_q  <= fl_cnt_d;
      bf_wr_q   <= bf_wr_d;
      bf_rd_q   <= bf_rd_d;
      bf_cnt_q  <= bf_cnt_d;
      discard_q <= discard_d;
`ifdef IF_ADEL_CHECK_EN
      adel_hold_q <= adel_hold_d;
`endif
    end
  end

  // NOTE: queue storage has no reset; only the counters/pointers qualify it, and outputs are
  // gated by if_valid, so clearing the arrays would only cost flops and reset fanout.
  always_ff @(posedge clk) begin
    if (accept) fl_pc_q[fl_wr_q] <= pc;
    if (bf_push) begin
      bf_pc_q[bf_wr_q]   <= push_pc;
      bf_inst_q[bf_wr_q] <= push_inst;
`ifdef IF_ADEL_CHECK_EN
      bf_adel_q[bf_wr_q] <= adel_push;
`endif
    end
  end

  assign if_valid = (bf_cnt_q != '0);
  assign if_pc    = if_valid ? bf_pc_q[bf_rd_q]   : 32'h0;
  assign if_inst  = if_valid ? bf_inst_q[bf_rd_q] : 32'h0;
`ifdef IF_ADEL_CHECK_EN
  assign if_adel  = if_valid && bf_adel_q[bf_rd_q];
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs driven on the falling edge, outputs checked 1 ns later.
// Build with +define+IF_ADEL_CHECK_EN to exercise the misaligned-PC trap path.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        pc_stall;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef IF_ADEL_CHECK_EN
  logic        if_adel;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_fetch #(.DEPTH(2), .CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .flush        (flush),
    .pc_stall     (pc_stall),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_pc        (if_pc),
    .if_inst      (if_inst)
`ifdef IF_ADEL_CHECK_EN
    ,
    .if_adel      (if_adel)
`endif
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0; if_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   inst_req, 0);
    check("rst_stall", pc_stall, 1);
    check("rst_valid", if_valid, 0);
    check("rst_pc",    if_pc,    0);
    check("rst_inst",  if_inst,  0);

    // Single fetch: accept, data one cycle later, if_valid one cycle after data_ok
    @(negedge clk); reset = 1'b0; pc = 32'hbfc00000; inst_addr_ok = 1'b1; if_ready = 1'b1; #1;
    check("t1_req",       inst_req,  1);
    check("t1_stall_acc", pc_stall,  0);
    check("t1_addr",      inst_addr, 32'hbfc00000);
    @(negedge clk); inst_addr_ok = 1'b0; pc = 32'hbfc00004;
    inst_data_ok = 1'b1; inst_rdata = 32'h3c080001; #1;
    check("t1_valid_early", if_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; #1;
    check("t1_valid",      if_valid, 1);
    check("t1_pc",         if_pc,    32'hbfc00000);
    check("t1_inst",       if_inst,  32'h3c080001);
    check("t1_stall_idle", pc_stall, 1);
    @(negedge clk); #1;
    check("t1_drained", if_valid, 0);

    // Backpressure: two accepts fill credit, one pop frees exactly one request
    @(negedge clk); if_ready = 1'b0; inst_addr_ok = 1'b1; pc = 32'hbfc00004; #1;
    check("t2_req0", inst_req, 1);
    @(negedge clk); pc = 32'hbfc00008; inst_data_ok = 1'b1; inst_rdata = 32'h8c090000; #1;
    check("t2_req1", inst_req, 1);
    @(negedge clk); pc = 32'hbfc0000c; inst_rdata = 32'h2529ffff; #1;
    check("t2_full_req",   inst_req, 0);
    check("t2_full_stall", pc_stall, 1);
    @(negedge clk); inst_data_ok = 1'b0; #1;
    check("t2_hold_req",   inst_req, 0);
    check("t2_hold_stall", pc_stall, 1);
    check("t2_head_valid", if_valid, 1);
    check("t2_head_pc",    if_pc,    32'hbfc00004);
    check("t2_head_inst",  if_inst,  32'h8c090000);
    @(negedge clk); #1;
    check("t2_stable_pc", if_pc,    32'hbfc00004);
    check("t2_still_req", inst_req, 0);
    @(negedge clk); if_ready = 1'b1; #1;
    check("t2_pop_req", inst_req, 0);
    @(negedge clk); if_ready = 1'b0; #1;
    check("t2_new_req",   inst_req, 1);
    check("t2_new_stall", pc_stall, 0);
    check("t2_next_pc",   if_pc,    32'hbfc00008);
    check("t2_next_inst", if_inst,  32'h2529ffff);
    @(negedge clk); pc = 32'hbfc00010; inst_data_ok = 1'b1; inst_rdata = 32'h1520fffe; #1;
    check("t2_one_req", inst_req, 0);
    @(negedge clk); inst_data_ok = 1'b0; inst_addr_ok = 1'b0; if_ready = 1'b1; #1;
    check("t2_drain_pc0", if_pc, 32'hbfc00008);
    @(negedge clk); #1;
    check("t2_drain_pc1",   if_pc,   32'hbfc0000c);
    check("t2_drain_inst1", if_inst, 32'h1520fffe);
    @(negedge clk); #1;
    check("t2_drained", if_valid, 0);

    // Flush with two in flight: two stale responses dropped, third is the new target
    @(negedge clk); pc = 32'h80000000; inst_addr_ok = 1'b1; #1;
    check("t3_req0", inst_req, 1);
    @(negedge clk); pc = 32'h80000004; #1;
    check("t3_req1", inst_req, 1);
    @(negedge clk); pc = 32'h80000008; flush = 1'b1; #1;
    check("t3_flush_req",   inst_req, 0);
    check("t3_flush_stall", pc_stall, 0);
    @(negedge clk); flush = 1'b0; pc = 32'hbfc00380; inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef; #1;
    check("t3_no_credit", inst_req, 0);
    check("t3_stall",     pc_stall, 1);
    @(negedge clk); inst_rdata = 32'hdeadbee0; #1;
    check("t3_resume_req",  inst_req,  1);
    check("t3_resume_addr", inst_addr, 32'hbfc00380);
    @(negedge clk); inst_addr_ok = 1'b0; pc = 32'hbfc00384; inst_rdata = 32'h40806000; #1;
    check("t3_dropped", if_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; #1;
    check("t3_valid", if_valid, 1);
    check("t3_pc",    if_pc,    32'hbfc00380);
    check("t3_inst",  if_inst,  32'h40806000);
    @(negedge clk); #1;
    check("t3_drained", if_valid, 0);

    // Flush coinciding with data_ok, two in flight: exactly one discard remains
    @(negedge clk); pc = 32'h90000000; inst_addr_ok = 1'b1; if_ready = 1'b0; #1;
    check("t4_req0", inst_req, 1);
    @(negedge clk); pc = 32'h90000004; #1;
    check("t4_req1", inst_req, 1);
    @(negedge clk); pc = 32'h90000008; inst_addr_ok = 1'b0; flush = 1'b1;
    inst_data_ok = 1'b1; inst_rdata = 32'h11111111; #1;
    check("t4_flush_req", inst_req, 0);
    @(negedge clk); flush = 1'b0; inst_data_ok = 1'b0; pc = 32'ha0000000; inst_addr_ok = 1'b1; #1;
    check("t4_buf_empty", if_valid, 0);
    check("t4_credit",    inst_req, 1);
    @(negedge clk); inst_addr_ok = 1'b0; pc = 32'ha0000004; inst_data_ok = 1'b1; inst_rdata = 32'h22222222; #1;
    check("t4_wait", if_valid, 0);
    @(negedge clk); inst_rdata = 32'h33333333; #1;
    check("t4_drop", if_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; if_ready = 1'b1; #1;
    check("t4_valid", if_valid, 1);
    check("t4_pc",    if_pc,    32'ha0000000);
    check("t4_inst",  if_inst,  32'h33333333);
    @(negedge clk); if_ready = 1'b0; #1;
    check("t4_drained", if_valid, 0);

    // Reset mid-operation (with a simultaneous flush) clears everything
    @(negedge clk); pc = 32'hc0000000; inst_addr_ok = 1'b1; #1;
    check("t5_req0", inst_req, 1);
    @(negedge clk); pc = 32'hc0000004; inst_data_ok = 1'b1; inst_rdata = 32'h44444444; #1;
    check("t5_req1", inst_req, 1);
    @(negedge clk); inst_data_ok = 1'b0; pc = 32'hc0000008; reset = 1'b1; flush = 1'b1; #1;
    check("t5_pre_valid", if_valid, 1);
    check("t5_rst_req",   inst_req, 0);
    check("t5_rst_stall", pc_stall, 1);
    @(negedge clk); reset = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; pc = 32'hbfc00000; #1;
    check("t5_valid", if_valid, 0);
    check("t5_pc",    if_pc,    0);
    check("t5_inst",  if_inst,  0);
    check("t5_stall", pc_stall, 1);
    inst_addr_ok = 1'b1; #1;
    check("t5_req", inst_req, 1);
    @(negedge clk); pc = 32'hbfc00004; inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c080001; #1;
    check("t5_valid_early", if_valid, 0);
    @(negedge clk); inst_data_ok = 1'b0; if_ready = 1'b1; #1;
    check("t5_fetch_valid", if_valid, 1);
    check("t5_fetch_pc",    if_pc,    32'hbfc00000);
    check("t5_fetch_inst",  if_inst,  32'h3c080001);

`ifdef IF_ADEL_CHECK_EN
    // Misaligned PC produces an address-error entry and holds the PC until flush
    @(negedge clk); if_ready = 1'b0; pc = 32'hbfc00002; inst_addr_ok = 1'b1; #1;
    check("t6_req",   inst_req, 0);
    check("t6_stall", pc_stall, 1);
    @(negedge clk); #1;
    check("t6_valid",      if_valid, 1);
    check("t6_adel",       if_adel,  1);
    check("t6_inst",       if_inst,  0);
    check("t6_pc",         if_pc,    32'hbfc00002);
    check("t6_hold_req",   inst_req, 0);
    check("t6_hold_stall", pc_stall, 1);
    if_ready = 1'b1;
    @(negedge clk); if_ready = 1'b0; #1;
    check("t6_popped",     if_valid, 0);
    check("t6_held_stall", pc_stall, 1);
    check("t6_held_req",   inst_req, 0);
    @(negedge clk); flush = 1'b1; #1;
    check("t6_flush_stall", pc_stall, 0);
    @(negedge clk); flush = 1'b0; pc = 32'hbfc00380; inst_addr_ok = 1'b0; #1;
    check("t6_resume_req", inst_req, 1);
    check("t6_no_adel",    if_adel,  0);
`else
    // Without the check, a misaligned PC goes out on the bus unchanged
    @(negedge clk); if_ready = 1'b0; pc = 32'hbfc00002; inst_addr_ok = 1'b0; #1;
    check("t6_mis_req",  inst_req,  1);
    check("t6_mis_addr", inst_addr, 32'hbfc00002);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
